// File: rtl/regfile_read_ctrl.sv
// Register-file read controller.
// Accepts a two-port read request, drives one-hot row enables into the cell
// array for one cycle, captures the shared bitlines (or same-cycle write data
// when the written row matches) and presents the result until it is consumed.
module regfile_read_ctrl #(
    parameter int NUM_REGS = 16,
    parameter int WIDTH    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ReqValid,
    output logic                ReqReady,
    input  logic [3:0]          SrcReg1,
    input  logic [3:0]          SrcReg2,
    output logic [NUM_REGS-1:0] ReadEnable1,
    output logic [NUM_REGS-1:0] ReadEnable2,
    input  logic [WIDTH-1:0]    Bitline1,
    input  logic [WIDTH-1:0]    Bitline2,
    input  logic                WriteEnable,
    input  logic [3:0]          WriteReg,
    input  logic [WIDTH-1:0]    WriteData,
    output logic                RspValid,
    input  logic                RspReady,
    output logic [WIDTH-1:0]    SrcData1,
    output logic [WIDTH-1:0]    SrcData2
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [3:0]        idx1_r;
    logic [3:0]        idx2_r;
    logic [3:0]        idx1_next_s;
    logic [3:0]        idx2_next_s;
    logic [WIDTH-1:0]  data1_next_s;
    logic [WIDTH-1:0]  data2_next_s;
    logic              accept_s;

    // Row index to one-hot enable vector; indices beyond NUM_REGS select nothing.
    function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
        logic [NUM_REGS-1:0] vec;
        vec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            vec[i] = (idx == 4'(i));
        end
        return vec;
    endfunction

    // Request acceptance: free in IDLE, or in HOLD when the response leaves this cycle.
    always_comb begin
        ReqReady = 1'b0;
        case (state_r)
            IDLE:    ReqReady = ~rst;
            HOLD:    ReqReady = ~rst & RspReady;
            DRIVE:   ReqReady = 1'b0;
            default: ReqReady = 1'b0;
        endcase
        accept_s = ReqValid & ReqReady;
    end

    // Next-state, index latch and capture-data selection.
    always_comb begin
        state_next_s = state_r;
        idx1_next_s  = idx1_r;
        idx2_next_s  = idx2_r;
        data1_next_s = SrcData1;
        data2_next_s = SrcData2;

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = DRIVE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DRIVE: begin
                state_next_s = HOLD;
            end
            HOLD: begin
                if (RspReady) begin
                    if (accept_s) begin
                        state_next_s = DRIVE;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase

        if (accept_s) begin
            idx1_next_s = SrcReg1;
            idx2_next_s = SrcReg2;
        end else begin
            idx1_next_s = idx1_r;
            idx2_next_s = idx2_r;
        end

        // Bitlines are only meaningful while the enables are driven; a write to the
        // same row in that cycle has not reached the bitline yet, so forward it.
        if (state_r == DRIVE) begin
            if (WriteEnable && (WriteReg == idx1_r)) begin
                data1_next_s = WriteData;
            end else begin
                data1_next_s = Bitline1;
            end
            if (WriteEnable && (WriteReg == idx2_r)) begin
                data2_next_s = WriteData;
            end else begin
                data2_next_s = Bitline2;
            end
        end else begin
            data1_next_s = SrcData1;
            data2_next_s = SrcData2;
        end
    end

    // State, indices, captured data and registered enable/valid outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            idx1_r      <= 4'd0;
            idx2_r      <= 4'd0;
            SrcData1    <= '0;
            SrcData2    <= '0;
            ReadEnable1 <= '0;
            ReadEnable2 <= '0;
            RspValid    <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            idx1_r   <= idx1_next_s;
            idx2_r   <= idx2_next_s;
            SrcData1 <= data1_next_s;
            SrcData2 <= data2_next_s;
            RspValid <= (state_next_s == HOLD);
            if (state_next_s == DRIVE) begin
                ReadEnable1 <= onehot(idx1_next_s);
                ReadEnable2 <= onehot(idx2_next_s);
            end else begin
                ReadEnable1 <= '0;
                ReadEnable2 <= '0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_read_ctrl.sv
// Self-checking bench for regfile_read_ctrl: directed scenarios plus a
// randomized run against a transaction-level model of the controller.
module tb_regfile_read_ctrl;

    logic        clk;
    logic        rst;
    logic        ReqValid;
    logic        ReqReady;
    logic [3:0]  SrcReg1;
    logic [3:0]  SrcReg2;
    logic [15:0] ReadEnable1;
    logic [15:0] ReadEnable2;
    logic [15:0] Bitline1;
    logic [15:0] Bitline2;
    logic        WriteEnable;
    logic [3:0]  WriteReg;
    logic [15:0] WriteData;
    logic        RspValid;
    logic        RspReady;
    logic [15:0] SrcData1;
    logic [15:0] SrcData2;

    logic [15:0] mem [16];
    int n_checks;
    int n_fails;

    regfile_read_ctrl #(.NUM_REGS(16), .WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .ReqValid(ReqValid), .ReqReady(ReqReady),
        .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
        .ReadEnable1(ReadEnable1), .ReadEnable2(ReadEnable2),
        .Bitline1(Bitline1), .Bitline2(Bitline2),
        .WriteEnable(WriteEnable), .WriteReg(WriteReg), .WriteData(WriteData),
        .RspValid(RspValid), .RspReady(RspReady),
        .SrcData1(SrcData1), .SrcData2(SrcData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cell array: write port
    always @(posedge clk) begin
        if (WriteEnable) mem[WriteReg] <= WriteData;
    end

    // Cell array: selected row drives the bitline, otherwise junk
    always_comb begin
        Bitline1 = 16'hDEAD;
        Bitline2 = 16'hDEAD;
        for (int i = 0; i < 16; i++) begin
            if (ReadEnable1 == (16'd1 << i)) Bitline1 = mem[i];
            if (ReadEnable2 == (16'd1 << i)) Bitline2 = mem[i];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cell(input logic [3:0] r, input logic [15:0] d);
        WriteEnable = 1'b1; WriteReg = r; WriteData = d;
        step();
        WriteEnable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ReqValid = 1'b1; SrcReg1 = 4'd4; SrcReg2 = 4'd4; RspReady = 1'b1;
        for (int i = 0; i < 16; i++) write_cell(4'(i), 16'($urandom));
        #1;
        n_checks++; if (ReqReady !== 1'b0) begin n_fails++; $display("FAIL reset_ready: got %b expected 0", ReqReady); end
        n_checks++; if (RspValid !== 1'b0) begin n_fails++; $display("FAIL reset_rspvalid: got %b expected 0", RspValid); end
        n_checks++; if ({ReadEnable1, ReadEnable2} !== 32'h0) begin n_fails++; $display("FAIL reset_enables: got %h expected 0", {ReadEnable1, ReadEnable2}); end
        n_checks++; if ({SrcData1, SrcData2} !== 32'h0) begin n_fails++; $display("FAIL reset_data: got %h expected 0", {SrcData1, SrcData2}); end
        // First edge after reset release accepts the request
        rst = 1'b0;
        #1;
        n_checks++; if (ReqReady !== 1'b1) begin n_fails++; $display("FAIL reset_ready_after: got %b expected 1", ReqReady); end
        step();
        ReqValid = 1'b0;
        n_checks++; if (ReadEnable1 !== 16'h0010) begin n_fails++; $display("FAIL reset_first_re1: got %h expected 0010", ReadEnable1); end
        step();
        n_checks++; if (RspValid !== 1'b1 || SrcData1 !== mem[4] || SrcData2 !== mem[4]) begin
            n_fails++; $display("FAIL reset_first_rsp: got v=%b %h/%h expected v=1 %h/%h", RspValid, SrcData1, SrcData2, mem[4], mem[4]); end
        step();
    endtask

    task automatic test_basic();
        write_cell(4'd3, 16'h1234);
        write_cell(4'd7, 16'hBEEF);
        ReqValid = 1'b1; SrcReg1 = 4'd3; SrcReg2 = 4'd7; RspReady = 1'b1;
        step();
        ReqValid = 1'b0;
        n_checks++; if (ReadEnable1 !== 16'h0008) begin n_fails++; $display("FAIL basic_re1: got %h expected 0008", ReadEnable1); end
        n_checks++; if (ReadEnable2 !== 16'h0080) begin n_fails++; $display("FAIL basic_re2: got %h expected 0080", ReadEnable2); end
        n_checks++; if (RspValid !== 1'b0 || ReqReady !== 1'b0) begin n_fails++; $display("FAIL basic_drive_flags: got v=%b r=%b expected 0/0", RspValid, ReqReady); end
        step();
        n_checks++; if (RspValid !== 1'b1) begin n_fails++; $display("FAIL basic_rspvalid: got %b expected 1", RspValid); end
        n_checks++; if (SrcData1 !== 16'h1234 || SrcData2 !== 16'hBEEF) begin n_fails++; $display("FAIL basic_data: got %h/%h expected 1234/beef", SrcData1, SrcData2); end
        n_checks++; if ({ReadEnable1, ReadEnable2} !== 32'h0) begin n_fails++; $display("FAIL basic_hold_re: got %h expected 0", {ReadEnable1, ReadEnable2}); end
        step();
        n_checks++; if (RspValid !== 1'b0) begin n_fails++; $display("FAIL basic_consumed: got %b expected 0", RspValid); end
    endtask

    task automatic test_bypass();
        write_cell(4'd5, 16'h0000);
        write_cell(4'd2, 16'h3C3C);
        ReqValid = 1'b1; SrcReg1 = 4'd5; SrcReg2 = 4'd2; RspReady = 1'b1;
        step();
        ReqValid = 1'b0;
        WriteEnable = 1'b1; WriteReg = 4'd5; WriteData = 16'hA5A5;
        step();
        WriteEnable = 1'b0;
        n_checks++; if (SrcData1 !== 16'hA5A5) begin n_fails++; $display("FAIL bypass_port1: got %h expected a5a5", SrcData1); end
        n_checks++; if (SrcData2 !== 16'h3C3C) begin n_fails++; $display("FAIL bypass_port2: got %h expected 3c3c", SrcData2); end
        step();
    endtask

    task automatic test_backpressure();
        write_cell(4'd9, 16'h0F0F);
        write_cell(4'd10, 16'hF0F0);
        ReqValid = 1'b1; SrcReg1 = 4'd9; SrcReg2 = 4'd10; RspReady = 1'b0;
        step();
        ReqValid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            ReqValid = 1'b1; SrcReg1 = 4'($urandom); SrcReg2 = 4'($urandom);
            #1;
            n_checks++; if (ReqReady !== 1'b0) begin n_fails++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, ReqReady); end
            n_checks++; if (RspValid !== 1'b1 || SrcData1 !== 16'h0F0F || SrcData2 !== 16'hF0F0) begin
                n_fails++; $display("FAIL bp_hold[%0d]: got v=%b %h/%h expected v=1 0f0f/f0f0", i, RspValid, SrcData1, SrcData2); end
            n_checks++; if ({ReadEnable1, ReadEnable2} !== 32'h0) begin n_fails++; $display("FAIL bp_re[%0d]: got %h expected 0", i, {ReadEnable1, ReadEnable2}); end
            step();
        end
        ReqValid = 1'b0; RspReady = 1'b1;
        #1;
        n_checks++; if (ReqReady !== 1'b1) begin n_fails++; $display("FAIL bp_release_ready: got %b expected 1", ReqReady); end
        step();
        n_checks++; if (RspValid !== 1'b0) begin n_fails++; $display("FAIL bp_consumed: got %b expected 0", RspValid); end
    endtask

    task automatic test_back_to_back();
        write_cell(4'd1, 16'h1111);
        write_cell(4'd15, 16'hFFF0);
        write_cell(4'd0, 16'h0001);
        ReqValid = 1'b1; SrcReg1 = 4'd1; SrcReg2 = 4'd1; RspReady = 1'b1;
        step();
        SrcReg1 = 4'd15; SrcReg2 = 4'd0;
        n_checks++; if (ReadEnable1 !== 16'h0002 || ReadEnable2 !== 16'h0002) begin n_fails++; $display("FAIL b2b_re_a: got %h/%h expected 0002/0002", ReadEnable1, ReadEnable2); end
        step();
        n_checks++; if (RspValid !== 1'b1 || SrcData1 !== 16'h1111 || SrcData2 !== 16'h1111) begin
            n_fails++; $display("FAIL b2b_rsp_a: got v=%b %h/%h expected v=1 1111/1111", RspValid, SrcData1, SrcData2); end
        n_checks++; if (ReqReady !== 1'b1) begin n_fails++; $display("FAIL b2b_ready_hold: got %b expected 1", ReqReady); end
        step();
        ReqValid = 1'b0;
        n_checks++; if (ReadEnable1 !== 16'h8000 || ReadEnable2 !== 16'h0001 || RspValid !== 1'b0) begin
            n_fails++; $display("FAIL b2b_re_b: got %h/%h v=%b expected 8000/0001 v=0", ReadEnable1, ReadEnable2, RspValid); end
        step();
        n_checks++; if (RspValid !== 1'b1 || SrcData1 !== 16'hFFF0 || SrcData2 !== 16'h0001) begin
            n_fails++; $display("FAIL b2b_rsp_b: got v=%b %h/%h expected v=1 fff0/0001", RspValid, SrcData1, SrcData2); end
        step();
    endtask

    task automatic test_reset_midop();
        ReqValid = 1'b1; SrcReg1 = 4'd3; SrcReg2 = 4'd7; RspReady = 1'b1;
        step();
        ReqValid = 1'b0; rst = 1'b1;
        step();
        n_checks++; if (RspValid !== 1'b0 || {SrcData1, SrcData2} !== 32'h0 || {ReadEnable1, ReadEnable2} !== 32'h0) begin
            n_fails++; $display("FAIL midrst_clear: got v=%b d=%h re=%h expected all 0", RspValid, {SrcData1, SrcData2}, {ReadEnable1, ReadEnable2}); end
        rst = 1'b0;
        step();
        n_checks++; if (RspValid !== 1'b0) begin n_fails++; $display("FAIL midrst_stale: got %b expected 0", RspValid); end
        ReqValid = 1'b1; SrcReg1 = 4'd7; SrcReg2 = 4'd3;
        step();
        ReqValid = 1'b0;
        step();
        n_checks++; if (RspValid !== 1'b1 || SrcData1 !== 16'hBEEF || SrcData2 !== 16'h1234) begin
            n_fails++; $display("FAIL midrst_new: got v=%b %h/%h expected v=1 beef/1234", RspValid, SrcData1, SrcData2); end
        step();
    endtask

    // Transaction model: an accepted request is "reading" for one cycle, then
    // becomes a presented response until the consumer takes it.
    task automatic test_random();
        bit          reading;
        bit          presenting;
        logic [3:0]  r1, r2;
        logic [15:0] d1, d2;
        bit          exp_ready;
        reading = 1'b0; presenting = 1'b0; r1 = 4'd0; r2 = 4'd0; d1 = 16'h0; d2 = 16'h0;
        for (int c = 0; c < 400; c++) begin
            ReqValid    = ($urandom_range(0, 2) != 0);
            RspReady    = ($urandom_range(0, 2) != 0);
            SrcReg1     = 4'($urandom);
            SrcReg2     = ($urandom_range(0, 3) == 0) ? SrcReg1 : 4'($urandom);
            WriteEnable = ($urandom_range(0, 3) == 0);
            WriteReg    = ($urandom_range(0, 1) == 0) ? r1 : 4'($urandom);
            WriteData   = 16'($urandom);
            #1;
            exp_ready = !reading && (!presenting || RspReady);
            n_checks++; if (ReqReady !== exp_ready) begin n_fails++; $display("FAIL rand_ready@%0d: got %b expected %b", c, ReqReady, exp_ready); end
            n_checks++; if (RspValid !== presenting) begin n_fails++; $display("FAIL rand_rspvalid@%0d: got %b expected %b", c, RspValid, presenting); end
            if (presenting) begin
                n_checks++; if (SrcData1 !== d1 || SrcData2 !== d2) begin n_fails++; $display("FAIL rand_data@%0d: got %h/%h expected %h/%h", c, SrcData1, SrcData2, d1, d2); end
            end
            n_checks++; if (ReadEnable1 !== (reading ? (16'd1 << r1) : 16'h0) || ReadEnable2 !== (reading ? (16'd1 << r2) : 16'h0)) begin
                n_fails++; $display("FAIL rand_re@%0d: got %h/%h reading=%b idx=%0d/%0d", c, ReadEnable1, ReadEnable2, reading, r1, r2); end
            if (reading) begin
                presenting = 1'b1;
                d1 = (WriteEnable && WriteReg == r1) ? WriteData : mem[r1];
                d2 = (WriteEnable && WriteReg == r2) ? WriteData : mem[r2];
            end else if (presenting && RspReady) begin
                presenting = 1'b0;
            end
            reading = ReqValid && exp_ready;
            if (reading) begin r1 = SrcReg1; r2 = SrcReg2; end
            step();
        end
        ReqValid = 1'b0; RspReady = 1'b1; WriteEnable = 1'b0;
        step(); step(); step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_fails = 0;
        rst = 1'b1; ReqValid = 1'b0; RspReady = 1'b1; SrcReg1 = 4'd0; SrcReg2 = 4'd0;
        WriteEnable = 1'b0; WriteReg = 4'd0; WriteData = 16'h0;
        step();
        test_reset();
        test_basic();
        test_bypass();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/regfile_read_ctrl.md
REGFILE_READ_CTRL -- requirements
Module: regfile_read_ctrl

Interface
REQ-001 Parameter: NUM_REGS, 16, number of register rows (4-bit register index).
REQ-002 Parameter: WIDTH, 16, bits per register row.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ReqValid  input  1  read request valid.
REQ-006 ReqReady  output  1  controller can accept a request this cycle.
REQ-007 SrcReg1, SrcReg2  input  4 each  register indices for read ports 1 and 2.
REQ-008 ReadEnable1, ReadEnable2  output  NUM_REGS each  one-hot row read enables, driven to the cell array.
REQ-009 Bitline1, Bitline2  input  WIDTH each  shared bitlines, driven by the selected row, floating otherwise.
REQ-010 WriteEnable  input  1  array write strobe for this cycle.
REQ-011 WriteReg  input  4  row being written.
REQ-012 WriteData  input  WIDTH  data being written.
REQ-013 RspValid  output  1  SrcData1/SrcData2 valid.
REQ-014 RspReady  input  1  consumer accepts the response.
REQ-015 SrcData1, SrcData2  output  WIDTH each  registered read results.

Function
REQ-016 The FSM SHALL have states IDLE, DRIVE and HOLD.
REQ-017 ReqReady SHALL be 1 in IDLE, 1 in HOLD only when RspReady=1, and 0 in DRIVE and during rst.
- Request handshake: ReqValid && ReqReady at a rising edge.
REQ-018 On a handshake, the controller SHALL latch SrcReg1/SrcReg2 and go to DRIVE.
REQ-019 In DRIVE, ReadEnable1/ReadEnable2 SHALL be one-hot at the latched indices; in all other states both SHALL be all-zero.
REQ-020 At the end of DRIVE, the controller SHALL capture Bitline1/Bitline2 into SrcData1/SrcData2 and go to HOLD.
- Bitlines are never sampled outside DRIVE.
REQ-021 Bypass: if WriteEnable=1 in the DRIVE cycle and WriteReg equals a port's latched index, that port SHALL capture WriteData instead of its bitline; each port is decided independently.
REQ-022 RspValid SHALL be 1 exactly in HOLD; SrcData1/SrcData2 SHALL stay stable while RspValid=1 and RspReady=0.
REQ-023 In HOLD, if RspReady=1 and ReqValid=1, the controller SHALL latch the new request and go to DRIVE (back-to-back).
- If RspReady=1 and ReqValid=0, it goes to IDLE.
- If RspReady=0, it stays in HOLD.
REQ-024 Latency: a handshake at edge N SHALL give ReadEnable asserted in cycle N+1 and RspValid=1 in cycle N+2.
- Sustained throughput: one request per 2 cycles.
REQ-025 SrcReg1 equal to SrcReg2 SHALL be legal; both enables then select the same row.
REQ-026 Requests with ReqValid=0 SHALL cause no state change; indices are don't-care.

Reset
REQ-027 While rst=1 at a rising edge, the controller SHALL enter IDLE and clear SrcData1, SrcData2 and the latched indices to 0.
REQ-028 During and after reset, RspValid, ReadEnable1 and ReadEnable2 SHALL be 0.
REQ-029 Reset in DRIVE or HOLD SHALL abort the operation; no response for it SHALL ever be presented.
REQ-030 The first request SHALL be accepted on the first edge after rst deasserts.

Verification
REQ-031 Basic read: cells R3=0x1234 and R7=0xBEEF; request (3,7) -> next cycle ReadEnable1=0x0008 and ReadEnable2=0x0080; following cycle RspValid=1, SrcData1=0x1234, SrcData2=0xBEEF.
REQ-032 Bypass: request (5,2) with R5=0x0000, and WriteEnable=1, WriteReg=5, WriteData=0xA5A5 in the DRIVE cycle -> SrcData1=0xA5A5, SrcData2=R2 bitline value.
REQ-033 Backpressure: RspReady=0 for 4 cycles in HOLD -> RspValid and data held constant, ReadEnable all-zero, ReqReady=0; RspReady=1 -> response consumed.
REQ-034 Back-to-back: ReqValid held high with RspReady=1, indices (1,1) then (15,0) -> responses in consecutive HOLD cycles 2 cycles apart, with correct data, enables one-hot each DRIVE.
REQ-035 Reset mid-op: rst=1 during DRIVE -> next cycle IDLE, RspValid=0, SrcData=0, no stale response; a new request completes normally.
